// File: rtl/lcd_timing_ctrl.sv
// Full-frame RGB LCD timing generator: h/v counters, HSYNC/VSYNC/DE, pixel request and coordinates.
// Optional LCD_PIX_PREFETCH_EN: pixel request/coordinates lead the panel syncs and DE by one lcd_clk.
module lcd_timing_ctrl #(
   parameter logic [10:0] H_SYNC  = 11'd1,
   parameter logic [10:0] H_BACK  = 11'd46,
   parameter logic [10:0] H_VALID = 11'd800,
   parameter logic [10:0] H_FRONT = 11'd210,
   parameter logic [10:0] V_SYNC  = 11'd1,
   parameter logic [10:0] V_BACK  = 11'd23,
   parameter logic [10:0] V_VALID = 11'd480,
   parameter logic [10:0] V_FRONT = 11'd22,
   parameter logic        HS_POL  = 1'b1,
   parameter logic        VS_POL  = 1'b1
) (
   input  logic        lcd_clk,
   input  logic        sys_rst_n,
   input  logic        disp_en,
   output logic        lcd_hs,
   output logic        lcd_vs,
   output logic        lcd_de,
   output logic        pix_req,
   output logic [10:0] pix_x,
   output logic [10:0] pix_y,
   output logic        frame_start,
   output logic        ctrl_busy
);

   // state    | meaning
   // ST_IDLE  | counters held at (0,0), outputs idle
   // ST_RUN   | counters free-running, display on
   // ST_DRAIN | display off requested; finish current frame, then idle
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

   localparam int H_TOTAL = int'(H_SYNC) + int'(H_BACK) + int'(H_VALID) + int'(H_FRONT);
   localparam int V_TOTAL = int'(V_SYNC) + int'(V_BACK) + int'(V_VALID) + int'(V_FRONT);

   generate
      if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_bad_total
         $error("lcd_timing_ctrl: H_TOTAL/V_TOTAL must not exceed 2047");
      end
   endgenerate

   localparam logic [10:0] H_HS_END = H_FRONT + H_SYNC;
   localparam logic [10:0] H_ACT    = H_FRONT + H_SYNC + H_BACK;
   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_VS_END = V_FRONT + V_SYNC;
   localparam logic [10:0] V_ACT    = V_FRONT + V_SYNC + V_BACK;
   localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);

   state_t      state, state_nxt;
   logic [10:0] h_cnt, v_cnt;
   logic        running, h_last, frame_end;
   logic        hs_c, vs_c, de_c, fs_c;
   logic [10:0] x_c, y_c;
   logic        hs_q, vs_q, de_q, fs_q;

   assign running   = (state != ST_IDLE);
   assign h_last    = (h_cnt == H_LAST);
   assign frame_end = h_last && (v_cnt == V_LAST);
   assign ctrl_busy = running;

   always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state <= ST_IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (disp_en) state_nxt = ST_RUN;
         ST_RUN:   if (!disp_en) state_nxt = ST_DRAIN;
         ST_DRAIN: begin
            if (disp_en)        state_nxt = ST_RUN;
            else if (frame_end) state_nxt = ST_IDLE;
         end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // The wrap at frame_end already returns the counters to (0,0) when DRAIN hands back to IDLE.
   always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (!running) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_last) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
      end else begin
         h_cnt <= h_cnt + 11'd1;
      end
   end

   always_comb begin
      hs_c = running && (h_cnt >= H_FRONT) && (h_cnt < H_HS_END);
      vs_c = running && (v_cnt >= V_FRONT) && (v_cnt < V_VS_END);
      de_c = running && (h_cnt >= H_ACT) && (v_cnt >= V_ACT);
      fs_c = running && (h_cnt == 11'd0) && (v_cnt == 11'd0);
      x_c  = de_c ? (h_cnt - H_ACT) : 11'd0;
      y_c  = de_c ? (v_cnt - V_ACT) : 11'd0;
   end

   always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         hs_q    <= ~HS_POL;
         vs_q    <= ~VS_POL;
         de_q    <= 1'b0;
         fs_q    <= 1'b0;
         pix_req <= 1'b0;
         pix_x   <= '0;
         pix_y   <= '0;
      end else begin
         hs_q    <= hs_c ? HS_POL : ~HS_POL;
         vs_q    <= vs_c ? VS_POL : ~VS_POL;
         de_q    <= de_c;
         fs_q    <= fs_c;
         pix_req <= de_c;
         pix_x   <= x_c;
         pix_y   <= y_c;
      end
   end

`ifdef LCD_PIX_PREFETCH_EN
   // Panel-side signals wait one more cycle so the renderer's RAM read lands with lcd_de.
   always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         lcd_hs      <= ~HS_POL;
         lcd_vs      <= ~VS_POL;
         lcd_de      <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         lcd_hs      <= hs_q;
         lcd_vs      <= vs_q;
         lcd_de      <= de_q;
         frame_start <= fs_q;
      end
   end
`else
   assign lcd_hs      = hs_q;
   assign lcd_vs      = vs_q;
   assign lcd_de      = de_q;
   assign frame_start = fs_q;
`endif

endmodule
